// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the arbiter: htrans encodings and arbiter states.
package ahb_pkg;

  localparam logic [1:0] AHB_IDLE   = 2'd0;
  localparam logic [1:0] AHB_BUSY   = 2'd1;
  localparam logic [1:0] AHB_NONSEQ = 2'd2;
  localparam logic [1:0] AHB_SEQ    = 2'd3;

  typedef enum logic [1:0] {
    ARB_PARK = 2'd0,
    ARB_OWN  = 2'd1,
    ARB_LOCK = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ahb_arb_rr.sv
// Combinational winner picker for the AHB arbiter.
// Default build: masked round-robin starting one past ptr (ptr itself is
// searched last, so a lone requester that already owns the bus wins again).
// AHB_ARB_FIXED_PRIO_EN: lowest requesting index wins, no pointer port.
module ahb_arb_rr #(
  parameter  int unsigned mst_c = 2,
  localparam int unsigned IW    = $clog2(mst_c)
) (
  input  logic [mst_c-1:0] req,
`ifndef AHB_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0]    ptr,
`endif
  output logic [mst_c-1:0] gnt_c,
  output logic [IW-1:0]    idx_c,
  output logic             any_c
);

`ifdef AHB_ARB_FIXED_PRIO_EN

  // Fixed priority: first set bit from index 0 upwards.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    for (int unsigned i = 0; i < mst_c; i++) begin
      if (!any_c && req[IW'(i)]) begin
        any_c          = 1'b1;
        idx_c          = IW'(i);
        gnt_c[IW'(i)]  = 1'b1;
      end
    end
  end

`else

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Round-robin: visit ptr+1, ptr+2, ... wrapping, ending on ptr.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= mst_c; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(mst_c)) sum = sum - (IW+1)'(mst_c);
      cand = sum[IW-1:0];
      if (!any_c && req[cand]) begin
        any_c       = 1'b1;
        idx_c       = cand;
        gnt_c[cand] = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/ahb_arb.sv
// AHB bus arbiter: grants one master at a time, holds through bursts and
// locked sequences, parks on def_m, and tracks address/data phase owners.
// Optional build macro AHB_ARB_FIXED_PRIO_EN replaces round-robin with
// fixed lowest-index priority and drops the pointer register.
module ahb_arb
  import ahb_pkg::*;
#(
  parameter  int unsigned mst_c = 2,
  parameter  int unsigned def_m = 0,
  localparam int unsigned IW    = $clog2(mst_c)
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [mst_c-1:0]      hbusreq,
  input  logic [mst_c-1:0]      hlock,
  input  logic [mst_c-1:0][1:0] htrans_m,
  input  logic                  hready,
  output logic [mst_c-1:0]      hgrant,
  output logic [IW-1:0]         hmaster,
  output logic [IW-1:0]         hmaster_d,
  output logic                  hmastlock
);

  localparam logic [mst_c-1:0] DEF_GNT = mst_c'(1) << def_m;
  localparam logic [IW-1:0]    DEF_IDX = IW'(def_m);

  arb_state_e       state, state_n;
  logic [mst_c-1:0] gnt_n;
  logic [IW-1:0]    mst_n, mstd_n;
  logic             ml_n;
  logic             rearb;

`ifndef AHB_ARB_FIXED_PRIO_EN
  logic [IW-1:0]    ptr, ptr_n;
`endif

  logic [mst_c-1:0] win_gnt_c;
  logic [IW-1:0]    win_idx_c;
  logic             win_any_c;

  logic [1:0]       own_trans_c;
  logic             own_req_c, own_lock_c, own_burst_c, own_done_c;

  // Current address-phase owner's view of the bus.
  assign own_trans_c = htrans_m[hmaster];
  assign own_req_c   = hbusreq[hmaster];
  assign own_lock_c  = hlock[hmaster];
  assign own_burst_c = (own_trans_c == AHB_SEQ) || (own_trans_c == AHB_BUSY);
  assign own_done_c  = (own_trans_c == AHB_IDLE) || (!own_req_c && !own_burst_c);

  ahb_arb_rr #(.mst_c(mst_c)) u_rr (
    .req   (hbusreq),
`ifndef AHB_ARB_FIXED_PRIO_EN
    .ptr   (ptr),
`endif
    .gnt_c (win_gnt_c),
    .idx_c (win_idx_c),
    .any_c (win_any_c)
  );

  // Next-state, grant and phase-owner logic; hready=0 holds everything.
  always_comb begin
    state_n = state;
    gnt_n   = hgrant;
    mst_n   = hmaster;
    mstd_n  = hmaster_d;
    ml_n    = hmastlock;
    rearb   = 1'b0;
`ifndef AHB_ARB_FIXED_PRIO_EN
    ptr_n   = ptr;
`endif
    if (hready) begin
      mstd_n = hmaster;
      ml_n   = own_lock_c && ((own_trans_c == AHB_NONSEQ) || (own_trans_c == AHB_SEQ));
      case (state)
        ARB_PARK: rearb = 1'b1;
        ARB_OWN:  rearb = own_done_c;
        ARB_LOCK: begin
          // Lock release rearbitrates at once, but never splits a burst.
          if (!own_lock_c) begin
            state_n = ARB_OWN;
            rearb   = !own_burst_c;
          end
        end
        default:  rearb = 1'b1;
      endcase
      if (rearb) begin
        if (win_any_c) begin
          gnt_n   = win_gnt_c;
          mst_n   = win_idx_c;
          state_n = hlock[win_idx_c] ? ARB_LOCK : ARB_OWN;
`ifndef AHB_ARB_FIXED_PRIO_EN
          ptr_n   = win_idx_c;
`endif
        end else begin
          gnt_n   = DEF_GNT;
          mst_n   = DEF_IDX;
          state_n = ARB_PARK;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state     <= ARB_PARK;
      hgrant    <= DEF_GNT;
      hmaster   <= DEF_IDX;
      hmaster_d <= DEF_IDX;
      hmastlock <= 1'b0;
`ifndef AHB_ARB_FIXED_PRIO_EN
      ptr       <= DEF_IDX;
`endif
    end else begin
      state     <= state_n;
      hgrant    <= gnt_n;
      hmaster   <= mst_n;
      hmaster_d <= mstd_n;
      hmastlock <= ml_n;
`ifndef AHB_ARB_FIXED_PRIO_EN
      ptr       <= ptr_n;
`endif
    end
  end

endmodule

// File: tb/tb_ahb_arb.sv
// Directed scoreboard bench for ahb_arb (mst_c=2, def_m=0).
module tb_ahb_arb;
  import ahb_pkg::*;

  localparam logic [1:0] TI = AHB_IDLE;
  localparam logic [1:0] TN = AHB_NONSEQ;
  localparam logic [1:0] TS = AHB_SEQ;

  logic            hclk;
  logic            hresetn;
  logic [1:0]      hbusreq;
  logic [1:0]      hlock;
  logic [1:0][1:0] htrans_m;
  logic            hready;
  logic [1:0]      hgrant;
  logic [0:0]      hmaster;
  logic [0:0]      hmaster_d;
  logic            hmastlock;

  typedef struct {
    logic [1:0] gnt;
    logic       mst;
    logic       mstd;
    logic       ml;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  ahb_arb #(.mst_c(2), .def_m(0)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans_m  (htrans_m),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmaster_d (hmaster_d),
    .hmastlock (hmastlock)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check.
  task automatic step(input string tag, input logic rst, input logic rdy,
                      input logic [1:0] req, input logic [1:0] lk,
                      input logic [1:0] t1, input logic [1:0] t0,
                      input logic [1:0] eg, input logic em, input logic emd,
                      input logic eml);
    exp_t e;
    hresetn     = rst;
    hready      = rdy;
    hbusreq     = req;
    hlock       = lk;
    htrans_m[1] = t1;
    htrans_m[0] = t0;
    e.gnt  = eg;
    e.mst  = em;
    e.mstd = emd;
    e.ml   = eml;
    sbq.push_back(e);
    @(posedge hclk);
    #1;
    e = sbq.pop_front();
    chk({tag, ".gnt"},  32'(hgrant),    32'(e.gnt));
    chk({tag, ".mst"},  32'(hmaster),   32'(e.mst));
    chk({tag, ".mstd"}, 32'(hmaster_d), 32'(e.mstd));
    chk({tag, ".lock"}, 32'(hmastlock), 32'(e.ml));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    step("rst0", 1'b0, 1'b1, 2'b00, 2'b00, TI, TI, 2'b01, 1'b0, 1'b0, 1'b0);
    step("rst1", 1'b0, 1'b1, 2'b11, 2'b11, TN, TN, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("rst.state", 32'(dut.state), 32'(ARB_PARK));

    // Park with no requests
    for (int i = 0; i < 5; i++)
      step("park", 1'b1, 1'b1, 2'b00, 2'b00, TI, TI, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("park.state", 32'(dut.state), 32'(ARB_PARK));

`ifndef AHB_ARB_FIXED_PRIO_EN
    // Both requesting, single NONSEQ then IDLE: grants alternate
    step("rr1", 1'b1, 1'b1, 2'b11, 2'b00, TI, TI, 2'b10, 1'b1, 1'b0, 1'b0);
    step("rr2", 1'b1, 1'b1, 2'b11, 2'b00, TN, TN, 2'b10, 1'b1, 1'b1, 1'b0);
    step("rr3", 1'b1, 1'b1, 2'b11, 2'b00, TI, TI, 2'b01, 1'b0, 1'b1, 1'b0);
    step("rr4", 1'b1, 1'b1, 2'b11, 2'b00, TN, TN, 2'b01, 1'b0, 1'b0, 1'b0);
    step("rr5", 1'b1, 1'b1, 2'b11, 2'b00, TI, TI, 2'b10, 1'b1, 1'b0, 1'b0);
    step("rr6", 1'b1, 1'b1, 2'b11, 2'b00, TN, TN, 2'b10, 1'b1, 1'b1, 1'b0);
    step("rr7", 1'b1, 1'b1, 2'b11, 2'b00, TI, TI, 2'b01, 1'b0, 1'b1, 1'b0);
    step("rr8", 1'b1, 1'b1, 2'b11, 2'b00, TN, TN, 2'b01, 1'b0, 1'b0, 1'b0);
`else
    // Fixed priority: master 0 keeps winning against master 1
    step("fp1", 1'b1, 1'b1, 2'b11, 2'b00, TI, TI, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++)
      step("fp", 1'b1, 1'b1, 2'b11, 2'b00, TI, (i % 2 == 0) ? TN : TI,
           2'b01, 1'b0, 1'b0, 1'b0);
`endif

    // INCR4 on master 0 is not broken by master 1 requesting
    step("b1", 1'b1, 1'b1, 2'b01, 2'b00, TI, TN, 2'b01, 1'b0, 1'b0, 1'b0);
    step("b2", 1'b1, 1'b1, 2'b11, 2'b00, TI, TS, 2'b01, 1'b0, 1'b0, 1'b0);
    step("b3", 1'b1, 1'b1, 2'b11, 2'b00, TI, TS, 2'b01, 1'b0, 1'b0, 1'b0);
    step("b4", 1'b1, 1'b1, 2'b10, 2'b00, TI, TS, 2'b01, 1'b0, 1'b0, 1'b0);
    step("b5", 1'b1, 1'b1, 2'b10, 2'b00, TI, TI, 2'b10, 1'b1, 1'b0, 1'b0);

    // Locked sequence on master 1 while master 0 requests
    step("l0", 1'b1, 1'b1, 2'b10, 2'b10, TI, TI, 2'b10, 1'b1, 1'b1, 1'b0);
    step("l1", 1'b1, 1'b1, 2'b11, 2'b10, TN, TI, 2'b10, 1'b1, 1'b1, 1'b1);
    step("l2", 1'b1, 1'b1, 2'b11, 2'b10, TN, TI, 2'b10, 1'b1, 1'b1, 1'b1);
    step("l3", 1'b1, 1'b1, 2'b11, 2'b10, TN, TI, 2'b10, 1'b1, 1'b1, 1'b1);
    chk("lock.state", 32'(dut.state), 32'(ARB_LOCK));
    step("l4", 1'b1, 1'b1, 2'b11, 2'b00, TI, TI, 2'b01, 1'b0, 1'b1, 1'b0);

    // Wait states freeze a pending switch to master 1
    for (int i = 0; i < 3; i++)
      step("ws", 1'b1, 1'b0, 2'b10, 2'b00, TI, TI, 2'b01, 1'b0, 1'b1, 1'b0);
    step("ws.go", 1'b1, 1'b1, 2'b10, 2'b00, TI, TI, 2'b10, 1'b1, 1'b0, 1'b0);

    // Requests drop: return to park
    step("pk", 1'b1, 1'b1, 2'b00, 2'b00, TI, TI, 2'b01, 1'b0, 1'b1, 1'b0);
    chk("pk.state", 32'(dut.state), 32'(ARB_PARK));

    // Reset in the middle of a transfer
    step("g1", 1'b1, 1'b1, 2'b10, 2'b00, TN, TI, 2'b10, 1'b1, 1'b0, 1'b0);
    step("g2", 1'b1, 1'b1, 2'b10, 2'b00, TN, TI, 2'b10, 1'b1, 1'b1, 1'b0);
    step("g3", 1'b0, 1'b1, 2'b10, 2'b00, TS, TI, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("g3.state", 32'(dut.state), 32'(ARB_PARK));
    step("g4", 1'b1, 1'b1, 2'b00, 2'b00, TI, TI, 2'b01, 1'b0, 1'b0, 1'b0);

    // Simultaneous requests after reset
`ifndef AHB_ARB_FIXED_PRIO_EN
    step("h1", 1'b1, 1'b1, 2'b11, 2'b00, TI, TI, 2'b10, 1'b1, 1'b0, 1'b0);
`else
    step("h1", 1'b1, 1'b1, 2'b11, 2'b00, TI, TI, 2'b01, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
